// File: rtl/sv_alu_pkg.sv
// Shared ALU constants: default result width and the reference clock period.
// Imported by every ALU-side block; it intentionally carries no types.
package sv_alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 8;
    localparam int unsigned CLK_PERIOD     = 10;

endpackage : sv_alu_pkg

// File: rtl/alu_out_fifo_if.sv
// ALU result bus: producer side (EX_ALU/EX_ALU_VLD/ALU_RDY) and consumer side
// (OUT_DATA/OUT_VLD/OUT_RDY). The FIFO is the slave; the ALU and consumer form the master.
interface alu_out_fifo_if
    import sv_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] EX_ALU;
    logic                  EX_ALU_VLD;
    logic                  ALU_RDY;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VLD;
    logic                  OUT_RDY;

    modport slave (
        input  EX_ALU, EX_ALU_VLD, OUT_RDY,
        output ALU_RDY, OUT_DATA, OUT_VLD
    );

    modport master (
        output EX_ALU, EX_ALU_VLD, OUT_RDY,
        input  ALU_RDY, OUT_DATA, OUT_VLD
    );

endinterface : alu_out_fifo_if

// File: rtl/alu_out_fifo_mem.sv
// Result storage: DEPTH x DATA_WIDTH register array with one synchronous write
// port and one asynchronous (fall-through) read port.
module alu_out_fifo_mem
    import sv_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  i_we,
    input  logic [PW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset; occupancy alone decides which entries are live,
    // so resetting it would only cost flops and reset fan-out.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : alu_out_fifo_mem

// File: rtl/alu_out_fifo.sv
// ALU output FIFO: circular buffer with early ALU_RDY throttling (SLACK entries held back
// for in-flight results) and sticky OVERFLOW. Optional RES_CNT pop counter: ALU_OUT_FIFO_STATS_EN.
module alu_out_fifo
    import sv_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned SLACK      = 2,
    localparam int unsigned CW        = $clog2(DEPTH + 1),
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    alu_out_fifo_if.slave bus,
    output logic [CW-1:0] CNT,
    output logic          OVERFLOW
`ifdef ALU_OUT_FIFO_STATS_EN
    ,
    output logic [15:0]   RES_CNT
`endif
);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] RDY_LIMIT = CW'(DEPTH - SLACK);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_overflow;
    logic                  r_alu_rdy;
    logic [CW-1:0]         w_cnt_next;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == FULL_CNT);
    assign w_rd    = !w_empty && bus.OUT_RDY;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign w_wr    = bus.EX_ALU_VLD && (!w_full || w_rd);
    assign w_drop  = bus.EX_ALU_VLD && w_full && !w_rd;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned
    // and infers a latch.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wr && !w_rd) begin
            w_cnt_next = r_cnt + CW'(1);
        end else if (w_rd && !w_wr) begin
            w_cnt_next = r_cnt - CW'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_alu_rdy  <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_cnt     <= w_cnt_next;
            r_alu_rdy <= (w_cnt_next <= RDY_LIMIT);
        end
    end

    alu_out_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.EX_ALU),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign bus.OUT_DATA = w_rd_data;
    assign bus.OUT_VLD  = !w_empty;
    assign bus.ALU_RDY  = r_alu_rdy;
    assign CNT          = r_cnt;
    assign OVERFLOW     = r_overflow;

`ifdef ALU_OUT_FIFO_STATS_EN
    logic [15:0] r_res_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_res_cnt <= '0;
        end else if (w_rd) begin
            r_res_cnt <= r_res_cnt + 16'd1;
        end
    end

    assign RES_CNT = r_res_cnt;
`endif

endmodule : alu_out_fifo

// File: tb/tb_alu_out_fifo.sv
// Scoreboard bench for alu_out_fifo: directed stimulus queues expected words,
// a negedge monitor pops and compares every accepted OUT_DATA.
module tb_alu_out_fifo;
    import sv_alu_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cnt;
    logic          overflow;
`ifdef ALU_OUT_FIFO_STATS_EN
    logic [15:0]   res_cnt;
    int            pop_count = 0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    alu_out_fifo_if #(.DATA_WIDTH(DW)) bus ();

    alu_out_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .SLACK      (2)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .bus      (bus),
        .CNT      (cnt),
        .OVERFLOW (overflow)
`ifdef ALU_OUT_FIFO_STATS_EN
        ,
        .RES_CNT  (res_cnt)
`endif
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.EX_ALU_VLD = 1'b0;
        bus.OUT_RDY    = 1'b1;
        for (int i = 0; i < 40 && cnt != '0; i++) tick();
        check("drain_empty", 32'(cnt), 32'd0);
        bus.OUT_RDY = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
        exp_q.delete();
`ifdef ALU_OUT_FIFO_STATS_EN
        pop_count = 0;
`endif
    endtask

    // Monitor: a pop happens at the next rising edge when OUT_VLD && OUT_RDY and no reset.
    always @(negedge clk) begin
        if (!rst && bus.OUT_VLD === 1'b1 && bus.OUT_RDY === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(bus.OUT_DATA), 32'hDEAD);
            end else begin
                check("out_data", 32'(bus.OUT_DATA), 32'(exp_q.pop_front()));
            end
`ifdef ALU_OUT_FIFO_STATS_EN
            pop_count++;
`endif
        end
    end

    initial begin
        int sent;
        bus.EX_ALU     = '0;
        bus.EX_ALU_VLD = 1'b0;
        bus.OUT_RDY    = 1'b0;

        do_reset(2);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_out_vld", 32'(bus.OUT_VLD), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_alu_rdy", 32'(bus.ALU_RDY), 32'd1);

        // Ordering and one-cycle fall-through latency.
        bus.OUT_RDY    = 1'b1;
        bus.EX_ALU     = 8'h11;
        bus.EX_ALU_VLD = 1'b1;
        exp_q.push_back(8'h11);
        check("no_bypass", 32'(bus.OUT_VLD), 32'd0);
        tick();
        check("first_vld", 32'(bus.OUT_VLD), 32'd1);
        check("first_data", 32'(bus.OUT_DATA), 32'h11);
        bus.EX_ALU = 8'h22;
        exp_q.push_back(8'h22);
        tick();
        bus.EX_ALU = 8'h33;
        exp_q.push_back(8'h33);
        tick();
        drain();

        // Fill to DEPTH with no consumer; ALU_RDY falls once CNT reaches 7.
        for (int i = 0; i < 8; i++) begin
            bus.EX_ALU     = 8'(i + 1);
            bus.EX_ALU_VLD = 1'b1;
            exp_q.push_back(8'(i + 1));
            tick();
            check("fill_cnt", 32'(cnt), 32'(i + 1));
            check("fill_alu_rdy", 32'(bus.ALU_RDY), (i + 1 <= 6) ? 32'd1 : 32'd0);
        end
        check("full_no_ovf", 32'(overflow), 32'd0);

        // Full with simultaneous write and read: accepted, no drop.
        bus.EX_ALU  = 8'hAA;
        bus.OUT_RDY = 1'b1;
        exp_q.push_back(8'hAA);
        tick();
        check("wr_rd_full_cnt", 32'(cnt), 32'd8);
        check("wr_rd_full_ovf", 32'(overflow), 32'd0);

        // Full with no read: word dropped, OVERFLOW set, state unchanged.
        bus.OUT_RDY = 1'b0;
        bus.EX_ALU  = 8'hFF;
        tick();
        bus.EX_ALU_VLD = 1'b0;
        check("drop_cnt", 32'(cnt), 32'd8);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_head", 32'(bus.OUT_DATA), 32'h02);
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("aa_consumed", 32'(exp_q.size()), 32'd0);

        do_reset(1);
        check("rst2_ovf", 32'(overflow), 32'd0);
        check("rst2_alu_rdy", 32'(bus.ALU_RDY), 32'd1);

        // Stream 20 words, consumer toggling, producer honouring ALU_RDY.
        sent = 0;
        for (int cyc = 0; cyc < 200 && sent < 20; cyc++) begin
            bus.OUT_RDY = cyc[0];
            if (bus.ALU_RDY) begin
                bus.EX_ALU     = 8'(8'h40 + sent);
                bus.EX_ALU_VLD = 1'b1;
                exp_q.push_back(8'(8'h40 + sent));
                sent++;
            end else begin
                bus.EX_ALU_VLD = 1'b0;
            end
            tick();
        end
        check("stream_sent", 32'(sent), 32'd20);
        drain();
        check("stream_no_ovf", 32'(overflow), 32'd0);
        check("stream_all_out", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation with overflow set and CNT=5.
        for (int i = 0; i < 9; i++) begin
            bus.EX_ALU     = 8'(8'h80 + i);
            bus.EX_ALU_VLD = 1'b1;
            if (i < 8) exp_q.push_back(8'(8'h80 + i));
            tick();
        end
        bus.EX_ALU_VLD = 1'b0;
        bus.OUT_RDY    = 1'b1;
        repeat (3) tick();
        bus.OUT_RDY = 1'b0;
        check("mid_cnt", 32'(cnt), 32'd5);
        check("mid_ovf", 32'(overflow), 32'd1);
        check("mid_head", 32'(bus.OUT_DATA), 32'h83);
`ifdef ALU_OUT_FIFO_STATS_EN
        check("res_cnt_pre", 32'(res_cnt), 32'(pop_count));
`endif
        bus.EX_ALU     = 8'h5A;
        bus.EX_ALU_VLD = 1'b1;
        bus.OUT_RDY    = 1'b1;
        do_reset(1);
        bus.EX_ALU_VLD = 1'b0;
        bus.OUT_RDY    = 1'b0;
        check("mid_rst_cnt", 32'(cnt), 32'd0);
        check("mid_rst_vld", 32'(bus.OUT_VLD), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_rdy", 32'(bus.ALU_RDY), 32'd1);
`ifdef ALU_OUT_FIFO_STATS_EN
        check("mid_rst_res_cnt", 32'(res_cnt), 32'd0);
`endif
        tick();
        check("post_rst_empty", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_out_fifo
